// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    TRAP = 2'b01,
    HALT = 2'b10
  } pcState_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_EXTERNAL = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  localparam int unsigned INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  topPtr;
  logic [PtrW-1:0]  ptrUp;
  logic [PtrW:0]    count;

  assign ptrUp = topPtr + 1'b1;
  assign empty = (count == '0);
  assign full  = (count == (PtrW+1)'(DEPTH));
  assign top   = mem[topPtr];

  // A simultaneous pop and push on a non-empty stack just replaces the top entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      topPtr <= '0;
      count  <= '0;
    end else if (push && pop && !empty) begin
      mem[topPtr] <= pushData;
    end else if (push) begin
      topPtr     <= ptrUp;
      mem[ptrUp] <= pushData;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      topPtr <= topPtr - 1'b1;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, redirects, precise traps and a halt state.
// Define PC_RAS_EN to add Call/Ret ports backed by a return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Exception,
  input  logic             Eret,
`ifdef PC_RAS_EN
  input  logic             Call,
  input  logic             Ret,
`endif
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlusInc,
  output logic [WIDTH-1:0] EPC,
  output logic [1:0]       Cause,
  output logic             Halted
);

  pcState_t         state, stateNext;
  logic [WIDTH-1:0] pcNext, epcNext, jumpDest, target;
  logic [1:0]       causeNext;
  logic             redirect, misaligned;

  assign PCPlusInc = PC + WIDTH'(INC);
  assign Halted    = (state == HALT);

`ifdef PC_RAS_EN
  logic [WIDTH-1:0] rasTop;
  logic             rasEmpty, unusedRasFull, rasStep;

  // The stack only moves when the jump itself is actually taken.
  assign rasStep = Jump && !Stall && !misaligned &&
                   (((state == RUN) && !Exception) || ((state == TRAP) && !Eret));
  assign jumpDest = (Ret && !rasEmpty) ? rasTop : JumpTarget;

  pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) ras (
    .clock    (Clk),
    .reset    (Reset),
    .push     (rasStep && Call),
    .pop      (rasStep && Ret),
    .pushData (PCPlusInc),
    .top      (rasTop),
    .empty    (rasEmpty),
    .full     (unusedRasFull)
  );
`else
  localparam int unusedRasDepth = RAS_DEPTH;
  assign jumpDest = JumpTarget;
`endif

  assign redirect   = !Stall && (Jump || Branch);
  assign target     = Jump ? jumpDest : BranchTarget;
  assign misaligned = redirect && (target[1:0] != 2'b00);

  // Next-PC selection: Exception > Eret > Stall > Jump > Branch > sequential.
  always_comb begin
    stateNext = state;
    pcNext    = PC;
    epcNext   = EPC;
    causeNext = Cause;
    case (state)
      RUN: begin
        if (Exception) begin
          pcNext    = EXC_VECTOR;
          epcNext   = PC;
          causeNext = CAUSE_EXTERNAL;
          stateNext = TRAP;
        end else if (Stall) begin
          pcNext = PC;
        end else if (misaligned) begin
          pcNext    = EXC_VECTOR;
          epcNext   = target;
          causeNext = CAUSE_MISALIGN;
          stateNext = TRAP;
        end else if (redirect) begin
          pcNext = target;
        end else begin
          pcNext = PCPlusInc;
        end
      end
      TRAP: begin
        if (Eret) begin
          pcNext    = EPC;
          causeNext = CAUSE_NONE;
          stateNext = RUN;
        end else if (Stall) begin
          pcNext = PC;
        end else if (misaligned) begin
          stateNext = HALT;
        end else if (redirect) begin
          pcNext = target;
        end else begin
          pcNext = PCPlusInc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      PC    <= RESET_VECTOR;
      EPC   <= '0;
      Cause <= CAUSE_NONE;
    end else begin
      state <= stateNext;
      PC    <= pcNext;
      EPC   <= epcNext;
      Cause <= causeNext;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized bench for pc_unit against a behavioural next-PC model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h8000_0180;
  localparam int          DEPTH = 4;

  logic        Clk = 1'b0;
  logic        rst, stall, branch, jump, exc, eret;
  logic [31:0] branchTarget, jumpTarget;
  logic [31:0] PC, PCPlusInc, EPC;
  logic [1:0]  Cause;
  logic        Halted;
`ifdef PC_RAS_EN
  logic        call, ret;
  logic [31:0] ras [$];
`endif

  // Reference state: mode 0 = running, 1 = in trap handler, 2 = halted.
  logic [31:0] mPc, mEpc;
  logic [1:0]  mCause;
  int          mMode;
  int          checks = 0;
  int          errors = 0;

  pc_unit dut (
    .Clk          (Clk),
    .Reset        (rst),
    .Stall        (stall),
    .Branch       (branch),
    .BranchTarget (branchTarget),
    .Jump         (jump),
    .JumpTarget   (jumpTarget),
    .Exception    (exc),
    .Eret         (eret),
`ifdef PC_RAS_EN
    .Call         (call),
    .Ret          (ret),
`endif
    .PC           (PC),
    .PCPlusInc    (PCPlusInc),
    .EPC          (EPC),
    .Cause        (Cause),
    .Halted       (Halted)
  );

  always #5 Clk = ~Clk;

  task automatic idleInputs();
    rst = 0; stall = 0; branch = 0; jump = 0; exc = 0; eret = 0;
    branchTarget = '0; jumpTarget = '0;
`ifdef PC_RAS_EN
    call = 0; ret = 0;
`endif
  endtask

  task automatic modelEdge();
    logic [31:0] tgt;
    logic        redir;
    if (rst) begin
      mPc = RV; mEpc = '0; mCause = 2'd0; mMode = 0;
`ifdef PC_RAS_EN
      ras.delete();
`endif
      return;
    end
    if (mMode == 2) return;
    redir = !stall && (jump || branch);
    tgt   = jump ? jumpTarget : branchTarget;
`ifdef PC_RAS_EN
    if (jump && ret && ras.size() > 0) tgt = ras[$];
`endif
    if (mMode == 0 && exc) begin
      mEpc = mPc; mPc = EV; mCause = 2'd1; mMode = 1;
    end else if (mMode == 1 && eret) begin
      mPc = mEpc; mCause = 2'd0; mMode = 0;
    end else if (stall) begin
      mPc = mPc;
    end else if (redir && tgt[1:0] != 2'b00) begin
      if (mMode == 0) begin
        mEpc = tgt; mPc = EV; mCause = 2'd2; mMode = 1;
      end else begin
        mMode = 2;
      end
    end else if (redir) begin
`ifdef PC_RAS_EN
      if (jump && ret && ras.size() > 0) void'(ras.pop_back());
      if (jump && call) begin
        ras.push_back(mPc + 32'd4);
        if (ras.size() > DEPTH) void'(ras.pop_front());
      end
`endif
      mPc = tgt;
    end else begin
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkVal({tag, " PC"}, PC, mPc);
    checkVal({tag, " PCPlusInc"}, PCPlusInc, mPc + 32'd4);
    checkVal({tag, " EPC"}, EPC, mEpc);
    checkVal({tag, " Cause"}, {30'd0, Cause}, {30'd0, mCause});
    checkVal({tag, " Halted"}, {31'd0, Halted}, (mMode == 2) ? 32'd1 : 32'd0);
  endtask

  // Inputs are already set; advance one edge, then compare 1ns later.
  task automatic applyStimulus(string tag);
    modelEdge();
    @(posedge Clk);
    #1;
    checkOutput(tag);
    idleInputs();
  endtask

  initial begin
    mPc = '0; mEpc = '0; mCause = '0; mMode = 0;
    idleInputs();

    rst = 1; applyStimulus("reset");
    checkVal("resetPC", PC, 32'h0040_0000);
    applyStimulus("idle1");
    applyStimulus("idle2");
    checkVal("idle2PC", PC, 32'h0040_0008);
    applyStimulus("idle3");
    checkVal("idle3PC", PC, 32'h0040_000C);

    rst = 1; applyStimulus("reset2");
    applyStimulus("seq1");
    applyStimulus("seq2");
    stall = 1; branch = 1; branchTarget = 32'h0040_0010; applyStimulus("stallBranch");
    checkVal("stallHeld", PC, 32'h0040_0008);
    branch = 1; branchTarget = 32'h0040_0010; applyStimulus("branchTaken");
    checkVal("branchPC", PC, 32'h0040_0010);

    exc = 1; applyStimulus("exception");
    checkVal("excPC", PC, 32'h8000_0180);
    checkVal("excEPC", EPC, 32'h0040_0010);
    checkVal("excCause", {30'd0, Cause}, 32'd1);
    eret = 1; applyStimulus("eret");
    checkVal("eretPC", PC, 32'h0040_0010);
    checkVal("eretCause", {30'd0, Cause}, 32'd0);

    jump = 1; jumpTarget = 32'h0040_0022; applyStimulus("misJump");
    checkVal("misPC", PC, 32'h8000_0180);
    checkVal("misEPC", EPC, 32'h0040_0022);
    checkVal("misCause", {30'd0, Cause}, 32'd2);
    jump = 1; jumpTarget = 32'h0040_0033; applyStimulus("misInTrap");
    checkVal("haltFlag", {31'd0, Halted}, 32'd1);
    checkVal("haltPC", PC, 32'h8000_0180);
    exc = 1; eret = 1; jump = 1; jumpTarget = 32'h100; applyStimulus("haltFrozen");
    rst = 1; applyStimulus("resetFromHalt");
    checkVal("haltExitPC", PC, 32'h0040_0000);

    jump = 1; jumpTarget = 32'hFFFF_FFFC; applyStimulus("jumpTop");
    checkVal("topPlusInc", PCPlusInc, 32'h0000_0000);
    applyStimulus("wrap");
    checkVal("wrapPC", PC, 32'h0000_0000);
    checkVal("wrapCause", {30'd0, Cause}, 32'd0);

    jump = 1; jumpTarget = 32'h100; branch = 1; branchTarget = 32'h200; applyStimulus("jumpOverBranch");
    checkVal("jumpPriority", PC, 32'h0000_0100);
    stall = 1; exc = 1; applyStimulus("excBeatsStall");
    exc = 1; eret = 1; applyStimulus("eretInTrap");
    checkVal("eretWinsPC", PC, 32'h0000_0100);

`ifdef PC_RAS_EN
    rst = 1; applyStimulus("rasReset");
    for (int k = 1; k <= 5; k++) begin
      jump = 1; call = 1; jumpTarget = 32'h1000 * k; applyStimulus("call");
    end
    checkVal("lastCallPC", PC, 32'h0000_5000);
    for (int k = 0; k < 5; k++) begin
      jump = 1; ret = 1; jumpTarget = 32'h9000; applyStimulus("ret");
      case (k)
        0: checkVal("ret1", PC, 32'h0000_4004);
        1: checkVal("ret2", PC, 32'h0000_3004);
        2: checkVal("ret3", PC, 32'h0000_2004);
        3: checkVal("ret4", PC, 32'h0000_1004);
        default: checkVal("ret5Empty", PC, 32'h0000_9000);
      endcase
    end
`endif

    rst = 1; applyStimulus("randReset");
    for (int n = 0; n < 800; n++) begin
      rst    = ($urandom_range(0, 99) < 2);
      exc    = ($urandom_range(0, 99) < 8);
      eret   = ($urandom_range(0, 99) < 12);
      stall  = ($urandom_range(0, 99) < 15);
      jump   = ($urandom_range(0, 99) < 25);
      branch = ($urandom_range(0, 99) < 25);
      jumpTarget   = $urandom() & 32'hFFFF_FFFC;
      branchTarget = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 6) jumpTarget[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 6) branchTarget[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 5) jumpTarget = 32'hFFFF_FFF8;
`ifdef PC_RAS_EN
      call = ($urandom_range(0, 99) < 50);
      ret  = ($urandom_range(0, 99) < 50);
`endif
      applyStimulus("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
